// File: rtl/fetch_pc_unit_if.sv
// Fetch-unit bus bundle: pipeline control, branch input, instruction ROM port and ID output.
// id_adel exists only when FETCH_ALIGN_CHECK_EN is defined.
interface fetch_pc_unit_if #(
  parameter int ADDR_W = 32
);
  logic              stall;
  logic              flush;
  logic [ADDR_W-1:0] flush_pc;
  logic              branch_flag;
  logic [ADDR_W-1:0] branch_addr;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_ready;
  logic [31:0]       rom_rdata;
  logic              id_valid;
  logic [ADDR_W-1:0] id_addr;
  logic [31:0]       id_inst;
`ifdef FETCH_ALIGN_CHECK_EN
  logic              id_adel;
`endif

  modport master (
`ifdef FETCH_ALIGN_CHECK_EN
    output id_adel,
`endif
    input  stall, flush, flush_pc, branch_flag, branch_addr, rom_ready, rom_rdata,
    output rom_en, rom_addr, id_valid, id_addr, id_inst
  );

  modport slave (
`ifdef FETCH_ALIGN_CHECK_EN
    input  id_adel,
`endif
    output stall, flush, flush_pc, branch_flag, branch_addr, rom_ready, rom_rdata,
    input  rom_en, rom_addr, id_valid, id_addr, id_inst
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// IF-stage PC generator: one ROM request at a time, held IF/ID register, MIPS delay-slot branches.
// Optional FETCH_ALIGN_CHECK_EN: misaligned PC delivers an address-error marker instead of fetching.
module fetch_pc_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'hBFC0_0000
) (
  input logic           clk,
  input logic           rst_n,
  fetch_pc_unit_if.master bus
);
  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              buf_valid_q, buf_valid_d;
  logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
  logic [31:0]       buf_inst_q, buf_inst_d;
  logic              id_valid_q, id_valid_d;
  logic [ADDR_W-1:0] id_addr_q, id_addr_d;
  logic [31:0]       id_inst_q, id_inst_d;
  logic              id_adel_q, id_adel_d;

  logic              misalign, rom_en, done, br_acc;
  logic [ADDR_W-1:0] pc_inc;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    buf_valid_d  = buf_valid_q;
    buf_addr_d   = buf_addr_q;
    buf_inst_d   = buf_inst_q;
    id_valid_d   = id_valid_q;
    id_addr_d    = id_addr_q;
    id_inst_d    = id_inst_q;
    id_adel_d    = id_adel_q;

`ifdef FETCH_ALIGN_CHECK_EN
    misalign = (pc_q[1:0] != 2'b00);
`else
    misalign = 1'b0;
`endif
    rom_en = (state_q == S_FETCH) && !misalign;
    done   = rom_en && bus.rom_ready;
    br_acc = id_valid_q && !bus.stall && bus.branch_flag;
    pc_inc = pc_q + ADDR_W'(4);

    if (br_acc) begin
      pend_valid_d = 1'b1;
      pend_addr_d  = bus.branch_addr;
    end

    case (state_q)
      S_BOOT: state_d = S_FETCH;
      S_FETCH: begin
        if (misalign) begin
          if (!bus.stall) begin
            id_valid_d = 1'b1;
            id_addr_d  = pc_q;
            id_inst_d  = '0;
            id_adel_d  = 1'b1;
          end
        end else if (done) begin
          // A branch leaving ID in this cycle makes the completing fetch its delay slot.
          pc_d         = br_acc ? bus.branch_addr : (pend_valid_q ? pend_addr_q : pc_inc);
          pend_valid_d = 1'b0;
          if (!bus.stall) begin
            id_valid_d = 1'b1;
            id_addr_d  = pc_q;
            id_inst_d  = bus.rom_rdata;
            id_adel_d  = 1'b0;
          end else begin
            buf_valid_d = 1'b1;
            buf_addr_d  = pc_q;
            buf_inst_d  = bus.rom_rdata;
            state_d     = S_HOLD;
          end
        end else if (!bus.stall) begin
          id_valid_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (!bus.stall) begin
          id_valid_d  = buf_valid_q;
          id_addr_d   = buf_addr_q;
          id_inst_d   = buf_inst_q;
          id_adel_d   = 1'b0;
          buf_valid_d = 1'b0;
          state_d     = S_FETCH;
          // The buffered instruction is already the delay slot, so redirect now.
          if (br_acc) begin
            pc_d         = bus.branch_addr;
            pend_valid_d = 1'b0;
          end
        end
      end
      default: state_d = S_FETCH;
    endcase

    if (bus.flush) begin
      state_d      = S_FETCH;
      pc_d         = bus.flush_pc;
      pend_valid_d = 1'b0;
      buf_valid_d  = 1'b0;
      id_valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_PC;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      buf_valid_q  <= 1'b0;
      buf_addr_q   <= '0;
      buf_inst_q   <= '0;
      id_valid_q   <= 1'b0;
      id_addr_q    <= '0;
      id_inst_q    <= '0;
      id_adel_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      buf_valid_q  <= buf_valid_d;
      buf_addr_q   <= buf_addr_d;
      buf_inst_q   <= buf_inst_d;
      id_valid_q   <= id_valid_d;
      id_addr_q    <= id_addr_d;
      id_inst_q    <= id_inst_d;
      id_adel_q    <= id_adel_d;
    end
  end

  assign bus.rom_en   = rom_en;
  assign bus.rom_addr = pc_q;
  assign bus.id_valid = id_valid_q;
  assign bus.id_addr  = id_addr_q;
  assign bus.id_inst  = id_inst_q;
`ifdef FETCH_ALIGN_CHECK_EN
  assign bus.id_adel  = id_adel_q;
`else
  logic unused_adel;
  assign unused_adel = id_adel_q;
`endif
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit; ROM returns addr ^ 32'h5A5A_0000 so id_inst is predictable.
module tb_fetch_pc_unit;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  fetch_pc_unit_if #(.ADDR_W(32)) bus ();
  assign bus.rom_rdata = bus.rom_addr ^ 32'h5A5A_0000;

  fetch_pc_unit #(.ADDR_W(32), .RESET_PC(32'hBFC0_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Inputs change on negedge; outputs are sampled on negedge after the preceding posedge.
  task tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task redirect(input logic [31:0] target);
    bus.flush = 1'b1; bus.flush_pc = target;
    tick();
    bus.flush = 1'b0;
  endtask

  task test_reset();
    rst_n = 1'b0;
    bus.stall = 0; bus.flush = 0; bus.flush_pc = '0;
    bus.branch_flag = 0; bus.branch_addr = '0; bus.rom_ready = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (bus.rom_en !== 1'b0) begin bad++; $display("FAIL reset_rom_en got=%b exp=0", bus.rom_en); end
    total++; if (bus.id_valid !== 1'b0) begin bad++; $display("FAIL reset_id_valid got=%b exp=0", bus.id_valid); end
    total++; if (bus.id_addr !== 32'h0) begin bad++; $display("FAIL reset_id_addr got=%h exp=0", bus.id_addr); end
    total++; if (bus.id_inst !== 32'h0) begin bad++; $display("FAIL reset_id_inst got=%h exp=0", bus.id_inst); end
    total++; if (bus.rom_addr !== 32'hBFC0_0000) begin bad++; $display("FAIL reset_rom_addr got=%h exp=bfc00000", bus.rom_addr); end
    rst_n = 1'b1;
    tick();  // BOOT
    total++; if (bus.rom_en !== 1'b1 || bus.rom_addr !== 32'hBFC0_0000) begin bad++; $display("FAIL boot_fetch got=%b/%h exp=1/bfc00000", bus.rom_en, bus.rom_addr); end
    tick();
    total++; if (bus.rom_addr !== 32'hBFC0_0004) begin bad++; $display("FAIL seq_rom_addr1 got=%h exp=bfc00004", bus.rom_addr); end
    total++; if (bus.id_valid !== 1'b1 || bus.id_addr !== 32'hBFC0_0000) begin bad++; $display("FAIL seq_id0 got=%b/%h exp=1/bfc00000", bus.id_valid, bus.id_addr); end
    total++; if (bus.id_inst !== 32'hE59A_0000) begin bad++; $display("FAIL seq_inst0 got=%h exp=e59a0000", bus.id_inst); end
    tick();
    total++; if (bus.rom_addr !== 32'hBFC0_0008 || bus.id_addr !== 32'hBFC0_0004) begin bad++; $display("FAIL seq_step2 got=%h/%h exp=bfc00008/bfc00004", bus.rom_addr, bus.id_addr); end
  endtask

  task test_branch();
    redirect(32'h100);
    total++; if (bus.id_valid !== 1'b0 || bus.rom_addr !== 32'h100) begin bad++; $display("FAIL br_start got=%b/%h exp=0/100", bus.id_valid, bus.rom_addr); end
    tick();
    total++; if (bus.id_addr !== 32'h100) begin bad++; $display("FAIL br_id100 got=%h exp=100", bus.id_addr); end
    bus.branch_flag = 1; bus.branch_addr = 32'h200;
    tick();
    bus.branch_flag = 0;
    total++; if (bus.id_addr !== 32'h104 || bus.rom_addr !== 32'h200) begin bad++; $display("FAIL br_slot got=%h/%h exp=104/200", bus.id_addr, bus.rom_addr); end
    tick();
    total++; if (bus.id_valid !== 1'b1 || bus.id_addr !== 32'h200) begin bad++; $display("FAIL br_target got=%b/%h exp=1/200", bus.id_valid, bus.id_addr); end
`ifdef FETCH_ALIGN_CHECK_EN
    total++; if (bus.id_adel !== 1'b0) begin bad++; $display("FAIL br_adel got=%b exp=0", bus.id_adel); end
`endif
  endtask

  task test_branch_wait();
    redirect(32'h100);
    tick();
    bus.branch_flag = 1; bus.branch_addr = 32'h200; bus.rom_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.branch_flag = 0;
      total++; if (bus.id_valid !== 1'b0 || bus.rom_addr !== 32'h104) begin bad++; $display("FAIL wait_bubble%0d got=%b/%h exp=0/104", i, bus.id_valid, bus.rom_addr); end
    end
    bus.rom_ready = 1;
    tick();
    total++; if (bus.id_addr !== 32'h104 || bus.rom_addr !== 32'h200) begin bad++; $display("FAIL wait_slot got=%h/%h exp=104/200", bus.id_addr, bus.rom_addr); end
    tick();
    total++; if (bus.id_addr !== 32'h200) begin bad++; $display("FAIL wait_target got=%h exp=200", bus.id_addr); end
  endtask

  task test_stall_hold();
    redirect(32'h100);
    tick(); tick();
    total++; if (bus.rom_addr !== 32'h108 || bus.id_addr !== 32'h104) begin bad++; $display("FAIL hold_pre got=%h/%h exp=108/104", bus.rom_addr, bus.id_addr); end
    bus.stall = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (bus.rom_en !== 1'b0 || bus.id_addr !== 32'h104 || bus.id_valid !== 1'b1) begin bad++; $display("FAIL hold_frozen%0d got=%b/%h/%b exp=0/104/1", i, bus.rom_en, bus.id_addr, bus.id_valid); end
    end
    bus.stall = 0;
    tick();
    total++; if (bus.id_addr !== 32'h108 || bus.id_inst !== 32'h5A5A_0108) begin bad++; $display("FAIL hold_release got=%h/%h exp=108/5a5a0108", bus.id_addr, bus.id_inst); end
    total++; if (bus.rom_en !== 1'b1 || bus.rom_addr !== 32'h10C) begin bad++; $display("FAIL hold_next got=%b/%h exp=1/10c", bus.rom_en, bus.rom_addr); end
    tick();
    total++; if (bus.id_addr !== 32'h10C) begin bad++; $display("FAIL hold_after got=%h exp=10c", bus.id_addr); end
  endtask

  task test_flush();
    // Flush while a branch is pending: target must be forgotten.
    redirect(32'h100);
    tick();
    bus.branch_flag = 1; bus.branch_addr = 32'h200; bus.rom_ready = 0;
    tick();
    bus.branch_flag = 0;
    redirect(32'hBFC0_0380);
    total++; if (bus.id_valid !== 1'b0 || bus.rom_addr !== 32'hBFC0_0380 || bus.rom_en !== 1'b1) begin bad++; $display("FAIL fl_pend got=%b/%h/%b exp=0/bfc00380/1", bus.id_valid, bus.rom_addr, bus.rom_en); end
    bus.rom_ready = 1;
    tick();
    total++; if (bus.id_addr !== 32'hBFC0_0380 || bus.rom_addr !== 32'hBFC0_0384) begin bad++; $display("FAIL fl_pend_drop got=%h/%h exp=bfc00380/bfc00384", bus.id_addr, bus.rom_addr); end
    // Flush while an instruction sits in the buffer.
    redirect(32'h100);
    bus.stall = 1;
    tick();
    total++; if (bus.rom_en !== 1'b0) begin bad++; $display("FAIL fl_buf_hold got=%b exp=0", bus.rom_en); end
    redirect(32'hBFC0_0380);
    total++; if (bus.id_valid !== 1'b0 || bus.rom_addr !== 32'hBFC0_0380 || bus.rom_en !== 1'b1) begin bad++; $display("FAIL fl_buf got=%b/%h/%b exp=0/bfc00380/1", bus.id_valid, bus.rom_addr, bus.rom_en); end
    bus.stall = 0;
    tick();
    total++; if (bus.id_valid !== 1'b1 || bus.id_addr !== 32'hBFC0_0380) begin bad++; $display("FAIL fl_buf_drop got=%b/%h exp=1/bfc00380", bus.id_valid, bus.id_addr); end
    // In-flight completion in the flush cycle is discarded.
    redirect(32'h400);
    total++; if (bus.id_valid !== 1'b0 || bus.rom_addr !== 32'h400) begin bad++; $display("FAIL fl_inflight got=%b/%h exp=0/400", bus.id_valid, bus.rom_addr); end
  endtask

  task test_wrap();
    redirect(32'hFFFF_FFFC);
    tick();
    total++; if (bus.id_addr !== 32'hFFFF_FFFC || bus.rom_addr !== 32'h0) begin bad++; $display("FAIL wrap got=%h/%h exp=fffffffc/0", bus.id_addr, bus.rom_addr); end
    total++; if (bus.id_inst !== 32'hA5A5_FFFC) begin bad++; $display("FAIL wrap_inst got=%h exp=a5a5fffc", bus.id_inst); end
  endtask

`ifdef FETCH_ALIGN_CHECK_EN
  task test_align();
    redirect(32'h100);
    tick();
    bus.branch_flag = 1; bus.branch_addr = 32'h202;
    tick();
    bus.branch_flag = 0;
    total++; if (bus.rom_en !== 1'b0 || bus.rom_addr !== 32'h202) begin bad++; $display("FAIL al_noreq got=%b/%h exp=0/202", bus.rom_en, bus.rom_addr); end
    tick();
    total++; if (bus.id_valid !== 1'b1 || bus.id_addr !== 32'h202 || bus.id_inst !== 32'h0 || bus.id_adel !== 1'b1) begin bad++; $display("FAIL al_adel got=%b/%h/%h/%b exp=1/202/0/1", bus.id_valid, bus.id_addr, bus.id_inst, bus.id_adel); end
    tick();
    total++; if (bus.rom_addr !== 32'h202 || bus.rom_en !== 1'b0) begin bad++; $display("FAIL al_pc_hold got=%h/%b exp=202/0", bus.rom_addr, bus.rom_en); end
  endtask
`endif

  initial begin
    test_reset();
    test_branch();
    test_branch_wait();
    test_stall_hold();
    test_flush();
    test_wrap();
`ifdef FETCH_ALIGN_CHECK_EN
    test_align();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
